// File: rtl/adder_pg_stage_pkg.sv
// Shared definitions for the adder generate/propagate front end.
//
// Contents:
//   LEN_DATA        MSB index of a data word (data width is LEN_DATA+1)
//   OP_W            opcode width
//   OP_ADD..OP_CMP  opcode encodings; 5..7 are illegal
//   op_inverts_b    opcode subtracts (operand B is inverted)
//   op_uses_cf      opcode consumes the architectural carry flag
//   op_is_illegal   opcode is outside the defined set
package adder_pg_stage_pkg;

  localparam int LEN_DATA = 31;
  localparam int OP_W     = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_ADC = 3'd2;
  localparam logic [OP_W-1:0] OP_SBC = 3'd3;
  localparam logic [OP_W-1:0] OP_CMP = 3'd4;

  function automatic logic op_inverts_b(input logic [OP_W-1:0] op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
  endfunction

  function automatic logic op_uses_cf(input logic [OP_W-1:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op > OP_CMP;
  endfunction

endpackage

// File: rtl/adder_pg_stage_pg_prep.sv
// Combinational operand preparation for the prefix adder.
// Inverts B for subtract-type opcodes, selects the carry-in and forms the
// per-bit generate/propagate vectors. The carry-in is folded into bit 0, so
// the prefix network needs no separate carry-in path.
//
// Ports:
//   a, b     operands
//   op       opcode (5..7 behave as ADD and raise illegal)
//   cf       carry flag value to use for ADC/SBC
//   g, p     generate / propagate vectors with bit-0 fold applied
//   cin      effective carry-in (needed again for the final sum)
//   illegal  opcode was outside the defined set
module adder_pg_stage_pg_prep
  import adder_pg_stage_pkg::*;
#(
  parameter int DATA_W = LEN_DATA + 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  input  logic              cf,
  output logic [DATA_W-1:0] g,
  output logic [DATA_W-1:0] p,
  output logic              cin,
  output logic              illegal
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] half;

  always_comb begin
    illegal = op_is_illegal(op);
    b_eff   = op_inverts_b(op) ? ~b : b;

    if (op == OP_SUB || op == OP_CMP) begin
      cin = 1'b1;
    end else if (op_uses_cf(op)) begin
      cin = cf;
    end else begin
      cin = 1'b0;
    end

    half = a ^ b_eff;
    g    = a & b_eff;
    p    = half;
    // Bit-0 fold: bit 0 generates if it would carry out given cin, and no
    // longer propagates, so prefix carries already include cin.
    g[0] = g[0] | (half[0] & cin);
    p[0] = half[0] & ~cin;
  end

endmodule

// File: rtl/adder_pg_stage.sv
// Pipelined front end of the prefix adder.
// Computes g/p for each accepted beat and registers it into a 2-entry skid
// buffer (main M drives the outputs, skid S catches the beat that arrives
// while M is stalled). Also holds the architectural carry flag.
//
// Handshake: a beat transfers on a clock edge where valid and ready are both
// high. in_ready is a register (~S.valid). While out_valid=1 and
// out_ready=0, all outputs are held stable.
//
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   flush                   synchronous drop of both entries and the input beat
//   in_valid/in_ready       upstream handshake
//   in_a, in_b, in_op, in_tag   operands, opcode, passthrough tag
//   cf_upd_valid, cf_upd    carry-flag write from the sum stage
//   out_valid/out_ready     downstream handshake
//   out_generate, out_propogate, out_cin, out_op, out_tag, out_illegal  beat
//   carry_flag              architectural carry flag
module adder_pg_stage
  import adder_pg_stage_pkg::*;
#(
  parameter int DATA_W = LEN_DATA + 1,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              cf_upd_valid,
  input  logic              cf_upd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_generate,
  output logic [DATA_W-1:0] out_propogate,
  output logic              out_cin,
  output logic [OP_W-1:0]   out_op,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  output logic              carry_flag
);

  typedef struct packed {
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic              cin;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic              illegal;
  } beat_t;

  beat_t m_q, s_q, new_beat;
  logic  m_valid, s_valid;
  logic  accept, drain, cf_eff;

  // A flag update landing in the same cycle as an ADC/SBC is bypassed so the
  // instruction sees the newest carry rather than the stale register.
  assign cf_eff = cf_upd_valid ? cf_upd : carry_flag;

  adder_pg_stage_pg_prep #(.DATA_W(DATA_W)) u_prep (
    .a       (in_a),
    .b       (in_b),
    .op      (in_op),
    .cf      (cf_eff),
    .g       (new_beat.g),
    .p       (new_beat.p),
    .cin     (new_beat.cin),
    .illegal (new_beat.illegal)
  );
  assign new_beat.op  = in_op;
  assign new_beat.tag = in_tag;

  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = m_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (drain) begin
      // S valid implies in_ready=0, so no accept can coincide with S->M.
      if (s_valid) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q <= new_beat;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (!m_valid) begin
      if (accept) begin
        m_valid <= 1'b1;
        m_q     <= new_beat;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_q     <= new_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_flag <= 1'b0;
    end else if (cf_upd_valid) begin
      carry_flag <= cf_upd;
    end
  end

  assign out_valid     = m_valid;
  assign out_generate  = m_q.g;
  assign out_propogate = m_q.p;
  assign out_cin       = m_q.cin;
  assign out_op        = m_q.op;
  assign out_tag       = m_q.tag;
  assign out_illegal   = m_q.illegal;

endmodule

// File: tb/tb_adder_pg_stage.sv
// Directed testbench for adder_pg_stage: hand-computed g/p vectors, carry
// flag bypass, skid-buffer backpressure ordering, flush, illegal opcode and
// asynchronous reset.
module tb_adder_pg_stage;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic              clk, rst, flush;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic [2:0]        in_op;
  logic [TAG_W-1:0]  in_tag;
  logic              cf_upd_valid, cf_upd;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_generate, out_propogate;
  logic              out_cin;
  logic [2:0]        out_op;
  logic [TAG_W-1:0]  out_tag;
  logic              out_illegal, carry_flag;

  int total  = 0;
  int passed = 0;

  adder_pg_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_op         (in_op),
    .in_tag        (in_tag),
    .cf_upd_valid  (cf_upd_valid),
    .cf_upd        (cf_upd),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_generate  (out_generate),
    .out_propogate (out_propogate),
    .out_cin       (out_cin),
    .out_op        (out_op),
    .out_tag       (out_tag),
    .out_illegal   (out_illegal),
    .carry_flag    (carry_flag)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // advance one edge, settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
  endtask

  // Ripple reference built only from the folded g/p: carries start at 0 and
  // bit 0's carry-out is g[0], so the sum is correct only if the fold is.
  function automatic logic [31:0] sum_from_gp(input logic [31:0] g, input logic [31:0] p,
                                              input logic [31:0] half, input logic cin);
    logic [31:0] s;
    logic        c;
    c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      s[i] = half[i] ^ ((i == 0) ? cin : c);
      c    = g[i] | (p[i] & c);
    end
    return s;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_op = 3'd0; in_tag = '0; cf_upd_valid = 1'b0; cf_upd = 1'b0; out_ready = 1'b1;

    // reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_carry_flag", carry_flag, 0);
    check("rst_gen", out_generate, 0);
    check("rst_prop", out_propogate, 0);
    check("rst_tag", out_tag, 0);
    tick();
    rst = 1'b0;

    // ADD 0xFF + 1
    drive(32'h0000_00FF, 32'h0000_0001, 3'd0, 4'd1);
    tick();
    in_valid = 1'b0;
    check("add_valid", out_valid, 1);
    check("add_gen", out_generate, 32'h0000_0001);
    check("add_prop", out_propogate, 32'h0000_00FE);
    check("add_cin", out_cin, 0);
    check("add_tag", out_tag, 1);

    // SUB 5 - 3: b' = 0xFFFF_FFFC, cin = 1
    drive(32'd5, 32'd3, 3'd1, 4'd2);
    tick();
    in_valid = 1'b0;
    check("sub_gen", out_generate, 32'h0000_0005);
    check("sub_prop", out_propogate, 32'hFFFF_FFF8);
    check("sub_cin", out_cin, 1);
    check("sub_op", out_op, 1);
    check("sub_sum", sum_from_gp(out_generate, out_propogate, 32'd5 ^ 32'hFFFF_FFFC, out_cin), 32'd2);
    tick();
    check("sub_drained", out_valid, 0);

    // ADC with same-cycle flag update: bypass gives cin=1
    drive(32'd1, 32'd1, 3'd2, 4'd3);
    cf_upd_valid = 1'b1; cf_upd = 1'b1;
    check("adc_cf_before", carry_flag, 0);
    tick();
    in_valid = 1'b0; cf_upd_valid = 1'b0;
    check("adc_cin_bypass", out_cin, 1);
    check("adc_gen", out_generate, 32'h0000_0001);
    check("adc_prop", out_propogate, 32'h0000_0000);
    check("adc_cf_after", carry_flag, 1);

    // SBC 0 - 0 with carry_flag=1 from the register
    drive(32'd0, 32'd0, 3'd3, 4'd4);
    tick();
    in_valid = 1'b0;
    check("sbc_cin", out_cin, 1);
    check("sbc_gen", out_generate, 32'h0000_0001);
    check("sbc_prop", out_propogate, 32'hFFFF_FFFE);
    tick();

    // backpressure: tags 1,2,3 with out_ready low
    out_ready = 1'b0;
    drive(32'd1, 32'd0, 3'd0, 4'd1);
    tick();
    check("bp_m_tag1", out_tag, 1);
    check("bp_ready_after1", in_ready, 1);
    drive(32'd2, 32'd0, 3'd0, 4'd2);
    tick();
    check("bp_hold_tag1", out_tag, 1);
    check("bp_ready_after2", in_ready, 0);
    drive(32'd3, 32'd0, 3'd0, 4'd3);
    tick();
    check("bp_still_tag1", out_tag, 1);
    check("bp_still_prop1", out_propogate, 1);
    check("bp_still_valid", out_valid, 1);
    check("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_order_tag2", out_tag, 2);
    check("bp_prop2", out_propogate, 2);
    check("bp_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_order_tag3", out_tag, 3);
    check("bp_prop3", out_propogate, 3);
    tick();
    check("bp_empty", out_valid, 0);

    // flush with both entries full and a beat on the input
    out_ready = 1'b0;
    drive(32'd5, 32'd0, 3'd0, 4'd5);
    tick();
    drive(32'd6, 32'd0, 3'd0, 4'd6);
    tick();
    check("fl_full", in_ready, 0);
    drive(32'd7, 32'd0, 3'd0, 4'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_carry_flag", carry_flag, 1);
    tick();
    check("fl_beat_dropped", out_valid, 0);

    // illegal opcode 6 behaves as ADD
    out_ready = 1'b1;
    drive(32'd3, 32'd5, 3'd6, 4'd8);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("ill_flag", out_illegal, 1);
    check("ill_op", out_op, 6);
    check("ill_gen", out_generate, 32'h0000_0001);
    check("ill_prop", out_propogate, 32'h0000_0006);
    check("ill_cin", out_cin, 0);

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_carry_flag", carry_flag, 0);
    check("arst_in_ready", in_ready, 1);
    tick();
    #2;
    rst = 1'b0;
    check("arst_held_valid", out_valid, 0);

    // CMP 7 vs 7 after reset
    out_ready = 1'b1;
    tick();
    drive(32'd7, 32'd7, 3'd4, 4'd9);
    tick();
    in_valid = 1'b0;
    check("cmp_valid", out_valid, 1);
    check("cmp_illegal", out_illegal, 0);
    check("cmp_gen", out_generate, 32'h0000_0001);
    check("cmp_prop", out_propogate, 32'hFFFF_FFFE);
    check("cmp_cin", out_cin, 1);
    check("cmp_tag", out_tag, 9);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_pg_stage.md
Name: adder_pg_stage

Overview:
- Pipelined front end of the prefix adder: takes operands plus an opcode, applies operand inversion and carry-in, and produces the initial generate/propagate vectors consumed by the first prefix stage.
- Holds the architectural carry flag used by ADC/SBC; the flag is updated from the sum stage downstream.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so ready is fully registered.

Parameters:
DATA_W, `LEN_DATA+1 (32), operand and g/p vector width
TAG_W, 4, width of the passthrough instruction tag

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous flush; drops all buffered entries
in_valid  in  1  operand beat valid
in_ready  out  1  stage can accept a beat
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_op  in  3  0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 CMP, 5-7 illegal
in_tag  in  TAG_W  passthrough ID
cf_upd_valid  in  1  carry-flag write strobe from sum stage
cf_upd  in  1  new carry-flag value
out_valid  out  1  g/p beat valid
out_ready  in  1  prefix stage accepts beat
out_generate  out  DATA_W  g[i] = a[i] & b'[i]; bit 0 includes carry-in
out_propogate  out  DATA_W  p[i] = a[i] ^ b'[i]
out_cin  out  1  effective carry-in, forwarded for the final sum
out_op  out  3  opcode passthrough
out_tag  out  TAG_W  tag passthrough
out_illegal  out  1  opcode was 5-7
carry_flag  out  1  current architectural carry flag

Behaviour:
- Reset (async, rst=1): all entries invalid; out_valid=0, in_ready=1, carry_flag=0, and all data outputs 0.
- Operand prep:
  - b' = ~in_b for SUB, SBC and CMP; otherwise b' = in_b.
  - cin: ADD=0, SUB=1, CMP=1, ADC=cf, SBC=cf.
  - Illegal opcodes are treated as ADD with out_illegal=1.
- Bit-0 fold: out_generate[0] = a0&b'0 | (a0^b'0)&cin; out_propogate[0] = (a0^b'0)&~cin. With this fold, the prefix result carry into bit i is correct including cin.
- cf forwarding: cf is the carry_flag value, except when cf_upd_valid is high in the same cycle as an ADC/SBC is accepted; then cf = cf_upd (bypass).
- carry_flag register: loads cf_upd on any cycle with cf_upd_valid=1. flush does not affect it.
- Latency: an accepted beat appears at the outputs on the next clock edge (1 cycle). g/p are computed before registering.
- Buffer: main register M drives the outputs; skid register S.
  - in_ready = ~S.valid, registered.
  - Accept when in_valid & in_ready. If M is empty, or M drains this cycle (out_valid & out_ready), the beat goes to M; otherwise it goes to S.
  - When M drains and S is valid, S moves to M and S is cleared.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Simultaneous accept + drain with S empty: the new beat replaces M; out_valid stays 1.
- Full (S valid): in_ready=0. Upstream must hold in_valid and its data stable until accepted.
- out_valid/data stability: while out_valid=1 and out_ready=0, every output stays unchanged.
- flush: both entries are invalidated on the next edge, and the same-cycle input beat is discarded. in_ready=1 after that edge.
- Reset mid-operation: contents are lost immediately. No output handshake completes on the edge at which rst is deasserted.

Decomposition:
- Shared package/define file main.def.v holds `LEN_DATA, the opcode constants (OP_ADD..OP_CMP) and the opcode width (3).
- Natural sub-module: pg_prep, a combinational operand inversion, cin select and per-bit g/p with bit-0 fold. The top module owns the skid buffer and the carry flag.

Test Plan:
- ADD a=0x0000_00FF, b=0x0000_0001, out_ready=1 -> next cycle out_valid=1, g=0x0000_0001, p=0x0000_00FE, cin=0.
- SUB a=5, b=3 -> b'=0xFFFF_FFFC, cin=1; bit-0 fold g[0]=1, p[0]=0; full prefix+sum model gives 2.
- ADC with carry_flag=0 and cf_upd_valid=1, cf_upd=1 in the accept cycle -> out_cin=1 (bypass); carry_flag=1 next cycle.
- Backpressure: out_ready=0 for 3 cycles while driving 3 beats (tags 1,2,3) -> tags 1 and 2 held, in_ready=0 after the second accept, tag 3 waits; on release, order is 1,2,3 with no loss.
- flush with M and S full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, carry_flag unchanged.
- Opcode 6 -> out_illegal=1 with ADD semantics; async rst pulse mid-stream -> out_valid=0 and carry_flag=0 immediately, before the next clock edge.
